watch_set_ctrl: RTL and testbench

Time-setting controller for the watch datapath. Three pre-debounced push-buttons drive a mode/field state machine. On entry to set mode it snapshots the running time into shadow registers, lets the user edit one field at a time with calendar-correct wrap, then commits all fields to `watch_time` with a single-cycle load strobe. It also gates the 1 Hz enable so the clock does not advance while being set, and drives a blink enable for the display.

---
 rtl/watch_set_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: time-setting controller for the watch datapath.
// Detects button edges, walks a RUN/set-field state machine, holds shadow
// copies of the time that the user edits with calendar-correct wrap, and
// commits them to watch_time with a one-cycle load strobe. While setting,
// the 1 Hz enable is blocked and a blink enable is produced for the display.
module watch_set_ctrl #(
   parameter int YEAR_MAX = 9999,  // highest settable year, wraps to 0
   parameter int RST_YEAR = 2000   // shadow year after reset
) (
   input  logic        clk,
   input  logic        rst,        // asynchronous, active-low
   input  logic        clk1sec,
   input  logic        btn_mode,
   input  logic        btn_sel,
   input  logic        btn_up,
   input  logic [13:0] cur_year,
   input  logic [7:0]  cur_month,
   input  logic [7:0]  cur_day,
   input  logic [7:0]  cur_hour,
   input  logic [7:0]  cur_min,
   input  logic [7:0]  cur_sec,
   output logic        tick_out,
   output logic        load,
   output logic [13:0] set_year,
   output logic [7:0]  set_month,
   output logic [7:0]  set_day,
   output logic [7:0]  set_hour,
   output logic [7:0]  set_min,
   output logic [7:0]  set_sec,
   output logic [2:0]  field_sel,
   output logic        blink
);

   // The state encoding doubles as the field_sel output.
   typedef enum logic [2:0] {
      RUN     = 3'd0,
      S_YEAR  = 3'd1,
      S_MONTH = 3'd2,
      S_DAY   = 3'd3,
      S_HOUR  = 3'd4,
      S_MIN   = 3'd5,
      S_SEC   = 3'd6
   } state_t;

   localparam logic [13:0] YEAR_MAX_L = 14'(YEAR_MAX);
   localparam logic [13:0] RST_YEAR_L = 14'(RST_YEAR);

   // Gregorian leap-year rule.
   function automatic logic is_leap(input logic [13:0] y);
      logic div4;
      logic div100;
      logic div400;
      div4   = (y[1:0] == 2'b00);
      div100 = ((y % 14'd100) == 14'd0);
      div400 = ((y % 14'd400) == 14'd0);
      return (div4 && !div100) || div400;
   endfunction

   // Number of days in month m of year y.
   function automatic logic [7:0] days_in_month(input logic [13:0] y,
                                                input logic [7:0]  m);
      logic [7:0] dim;
      case (m)
         8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
         8'd2:                    dim = is_leap(y) ? 8'd29 : 8'd28;
         default:                 dim = 8'd31;
      endcase
      return dim;
   endfunction

   // Registers
   state_t      r_state;
   logic        r_mode_q;
   logic        r_sel_q;
   logic        r_up_q;
   logic        r_load;
   logic        r_blink;
   logic [13:0] r_year;
   logic [7:0]  r_month;
   logic [7:0]  r_day;
   logic [7:0]  r_hour;
   logic [7:0]  r_min;
   logic [7:0]  r_sec;

   // Next-state and helper wires
   state_t      w_state_nxt;
   logic        w_load_nxt;
   logic        w_blink_nxt;
   logic [13:0] w_year_nxt;
   logic [7:0]  w_month_nxt;
   logic [7:0]  w_day_nxt;
   logic [7:0]  w_hour_nxt;
   logic [7:0]  w_min_nxt;
   logic [7:0]  w_sec_nxt;

   logic        w_mode_edge;
   logic        w_sel_edge;
   logic        w_up_edge;
   logic        w_in_set;

   logic [13:0] w_year_inc;
   logic [7:0]  w_month_inc;
   logic [7:0]  w_day_inc;
   logic [7:0]  w_hour_inc;
   logic [7:0]  w_min_inc;
   logic [7:0]  w_sec_inc;
   logic [7:0]  w_dim_cur;
   logic [7:0]  w_dim_year_inc;
   logic [7:0]  w_dim_month_inc;

   // One-cycle pulse on each rising button level; holding gives one pulse.
   assign w_mode_edge = btn_mode & ~r_mode_q;
   assign w_sel_edge  = btn_sel  & ~r_sel_q;
   assign w_up_edge   = btn_up   & ~r_up_q;
   assign w_in_set    = (r_state != RUN);

   // Wrapping increments of each shadow field.
   assign w_year_inc  = (r_year  >= YEAR_MAX_L) ? 14'd0 : r_year + 14'd1;
   assign w_month_inc = (r_month >= 8'd12)      ? 8'd1  : r_month + 8'd1;
   assign w_hour_inc  = (r_hour  >= 8'd23)      ? 8'd0  : r_hour + 8'd1;
   assign w_min_inc   = (r_min   >= 8'd59)      ? 8'd0  : r_min + 8'd1;
   assign w_sec_inc   = (r_sec   >= 8'd59)      ? 8'd0  : r_sec + 8'd1;

   // Month lengths for the current shadow date and for each candidate edit,
   // so the day can be clamped in the same cycle as a year/month change.
   assign w_dim_cur       = days_in_month(r_year, r_month);
   assign w_dim_year_inc  = days_in_month(w_year_inc, r_month);
   assign w_dim_month_inc = days_in_month(r_year, w_month_inc);
   assign w_day_inc       = (r_day >= w_dim_cur) ? 8'd1 : r_day + 8'd1;

   // Next-state, shadow-edit and strobe logic; mode beats sel beats up.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_load_nxt  = 1'b0;
      w_blink_nxt = r_blink;
      w_year_nxt  = r_year;
      w_month_nxt = r_month;
      w_day_nxt   = r_day;
      w_hour_nxt  = r_hour;
      w_min_nxt   = r_min;
      w_sec_nxt   = r_sec;

      if (!w_in_set) begin
         w_blink_nxt = 1'b1;
         if (w_mode_edge) begin
            w_state_nxt = S_YEAR;
            w_year_nxt  = cur_year;
            w_month_nxt = cur_month;
            w_day_nxt   = cur_day;
            w_hour_nxt  = cur_hour;
            w_min_nxt   = cur_min;
            w_sec_nxt   = cur_sec;
         end
      end else if (w_mode_edge) begin
         w_state_nxt = RUN;
         w_load_nxt  = 1'b1;
         w_blink_nxt = 1'b1;
      end else if (w_sel_edge) begin
         w_blink_nxt = 1'b1;
         case (r_state)
            S_YEAR:  w_state_nxt = S_MONTH;
            S_MONTH: w_state_nxt = S_DAY;
            S_DAY:   w_state_nxt = S_HOUR;
            S_HOUR:  w_state_nxt = S_MIN;
            S_MIN:   w_state_nxt = S_SEC;
            S_SEC:   w_state_nxt = S_YEAR;
            default: w_state_nxt = RUN;
         endcase
      end else begin
         if (clk1sec) begin
            w_blink_nxt = ~r_blink;
         end
         if (w_up_edge) begin
            case (r_state)
               S_YEAR: begin
                  w_year_nxt = w_year_inc;
                  if (r_day > w_dim_year_inc) begin
                     w_day_nxt = w_dim_year_inc;
                  end
               end
               S_MONTH: begin
                  w_month_nxt = w_month_inc;
                  if (r_day > w_dim_month_inc) begin
                     w_day_nxt = w_dim_month_inc;
                  end
               end
               S_DAY:   w_day_nxt  = w_day_inc;
               S_HOUR:  w_hour_nxt = w_hour_inc;
               S_MIN:   w_min_nxt  = w_min_inc;
               S_SEC:   w_sec_nxt  = w_sec_inc;
               default: w_state_nxt = RUN;
            endcase
         end
      end
   end

   // State, strobe, blink, button history and shadow field registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst) begin
         r_state  <= RUN;
         r_mode_q <= 1'b0;
         r_sel_q  <= 1'b0;
         r_up_q   <= 1'b0;
         r_load   <= 1'b0;
         r_blink  <= 1'b1;
         r_year   <= RST_YEAR_L;
         r_month  <= 8'd1;
         r_day    <= 8'd1;
         r_hour   <= 8'd0;
         r_min    <= 8'd0;
         r_sec    <= 8'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode_q <= btn_mode;
         r_sel_q  <= btn_sel;
         r_up_q   <= btn_up;
         r_load   <= w_load_nxt;
         r_blink  <= w_blink_nxt;
         r_year   <= w_year_nxt;
         r_month  <= w_month_nxt;
         r_day    <= w_day_nxt;
         r_hour   <= w_hour_nxt;
         r_min    <= w_min_nxt;
         r_sec    <= w_sec_nxt;
      end
   end

   // The running clock only advances in RUN, never during the commit cycle,
   // and not on the cycle a set-mode entry edge is being taken.
   assign tick_out  = rst & clk1sec & ~w_in_set & ~r_load & ~w_mode_edge;

   assign load      = r_load;
   assign blink     = r_blink;
   assign field_sel = r_state;
   assign set_year  = r_year;
   assign set_month = r_month;
   assign set_day   = r_day;
   assign set_hour  = r_hour;
   assign set_min   = r_min;
   assign set_sec   = r_sec;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or #1 after an input change for
// the combinational tick_out).
module tb_watch_set_ctrl;

   logic        clk;
   logic        rst;
   logic        clk1sec;
   logic        btn_mode;
   logic        btn_sel;
   logic        btn_up;
   logic [13:0] cur_year;
   logic [7:0]  cur_month;
   logic [7:0]  cur_day;
   logic [7:0]  cur_hour;
   logic [7:0]  cur_min;
   logic [7:0]  cur_sec;
   logic        tick_out;
   logic        load;
   logic [13:0] set_year;
   logic [7:0]  set_month;
   logic [7:0]  set_day;
   logic [7:0]  set_hour;
   logic [7:0]  set_min;
   logic [7:0]  set_sec;
   logic [2:0]  field_sel;
   logic        blink;

   int n_tests = 0;
   int n_fail  = 0;

   watch_set_ctrl #(
      .YEAR_MAX (9999),
      .RST_YEAR (2000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clk1sec   (clk1sec),
      .btn_mode  (btn_mode),
      .btn_sel   (btn_sel),
      .btn_up    (btn_up),
      .cur_year  (cur_year),
      .cur_month (cur_month),
      .cur_day   (cur_day),
      .cur_hour  (cur_hour),
      .cur_min   (cur_min),
      .cur_sec   (cur_sec),
      .tick_out  (tick_out),
      .load      (load),
      .set_year  (set_year),
      .set_month (set_month),
      .set_day   (set_day),
      .set_hour  (set_hour),
      .set_min   (set_min),
      .set_sec   (set_sec),
      .field_sel (field_sel),
      .blink     (blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_cur(input int y, input int mo, input int d,
                          input int h, input int mi, input int s);
      cur_year  = 14'(y);
      cur_month = 8'(mo);
      cur_day   = 8'(d);
      cur_hour  = 8'(h);
      cur_min   = 8'(mi);
      cur_sec   = 8'(s);
   endtask

   // Called on a falling edge: hold the buttons for one clock, then release
   // them for one clock so the history registers return to 0.
   task automatic press(input logic m, input logic s, input logic u);
      btn_mode = m;
      btn_sel  = s;
      btn_up   = u;
      @(negedge clk);
      btn_mode = 1'b0;
      btn_sel  = 1'b0;
      btn_up   = 1'b0;
      @(negedge clk);
   endtask

   task automatic sel_n(input int n);
      for (int i = 0; i < n; i++) press(1'b0, 1'b1, 1'b0);
   endtask

   // Mode edge out of set mode (optionally with sel/up): load must be high
   // for exactly one cycle and tick_out must stay low during it.
   task automatic exit_set(input string tag, input logic s, input logic u);
      btn_mode = 1'b1;
      btn_sel  = s;
      btn_up   = u;
      @(negedge clk);
      btn_mode = 1'b0;
      btn_sel  = 1'b0;
      btn_up   = 1'b0;
      clk1sec  = 1'b1;
      #1;
      check({tag, "_load_hi"}, 32'(load), 32'd1);
      check({tag, "_field_run"}, 32'(field_sel), 32'd0);
      check({tag, "_tick_in_load"}, 32'(tick_out), 32'd0);
      @(negedge clk);
      clk1sec = 1'b0;
      check({tag, "_load_lo"}, 32'(load), 32'd0);
   endtask

   task automatic check_set(input string tag, input int y, input int mo,
                            input int d, input int h, input int mi,
                            input int s);
      check({tag, "_year"},  32'(set_year),  32'(y));
      check({tag, "_month"}, 32'(set_month), 32'(mo));
      check({tag, "_day"},   32'(set_day),   32'(d));
      check({tag, "_hour"},  32'(set_hour),  32'(h));
      check({tag, "_min"},   32'(set_min),   32'(mi));
      check({tag, "_sec"},   32'(set_sec),   32'(s));
   endtask

   initial begin
      rst      = 1'b0;
      clk1sec  = 1'b0;
      btn_mode = 1'b0;
      btn_sel  = 1'b0;
      btn_up   = 1'b0;
      set_cur(0, 0, 0, 0, 0, 0);

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_field", 32'(field_sel), 32'd0);
      check("rst_load",  32'(load),      32'd0);
      check("rst_blink", 32'(blink),     32'd1);
      check("rst_tick",  32'(tick_out),  32'd0);
      check_set("rst", 2000, 1, 1, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);

      // RUN passes the 1 Hz enable
      clk1sec = 1'b1;
      #1 check("run_tick", 32'(tick_out), 32'd1);
      @(negedge clk);
      clk1sec = 1'b0;

      // Entry with a coincident clk1sec: tick suppressed, snapshot taken
      set_cur(2024, 2, 29, 13, 45, 30);
      btn_mode = 1'b1;
      clk1sec  = 1'b1;
      #1 check("entry_tick_supp", 32'(tick_out), 32'd0);
      @(negedge clk);
      btn_mode = 1'b0;
      clk1sec  = 1'b0;
      check("entry_field", 32'(field_sel), 32'd1);
      check("entry_blink", 32'(blink), 32'd1);
      check_set("snap", 2024, 2, 29, 13, 45, 30);
      clk1sec = 1'b1;
      #1 check("set_tick_blocked", 32'(tick_out), 32'd0);
      @(negedge clk);
      clk1sec = 1'b0;
      check("blink_toggle", 32'(blink), 32'd0);

      // Exit with no edits commits exactly the snapshot
      exit_set("noedit", 1'b0, 1'b0);
      check_set("noedit_commit", 2024, 2, 29, 13, 45, 30);
      check("run_blink", 32'(blink), 32'd1);

      // Shadow stays stable in RUN while the running time moves
      set_cur(2023, 4, 30, 1, 2, 3);
      repeat (2) @(negedge clk);
      check("stable_year", 32'(set_year), 32'd2024);

      // Year increment clamps day 29 -> 28; month increment keeps 28
      set_cur(2024, 2, 29, 13, 45, 30);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      check("yinc_year", 32'(set_year), 32'd2025);
      check("yinc_clamp", 32'(set_day), 32'd28);
      clk1sec = 1'b1;
      @(negedge clk);
      clk1sec = 1'b0;
      check("blink_off", 32'(blink), 32'd0);
      sel_n(1);
      check("sel_month", 32'(field_sel), 32'd2);
      check("sel_blink_on", 32'(blink), 32'd1);
      press(1'b0, 1'b0, 1'b1);
      check("minc_month", 32'(set_month), 32'd3);
      check("minc_day", 32'(set_day), 32'd28);
      exit_set("ex1", 1'b0, 1'b0);

      // Day wrap at 30 in April
      set_cur(2023, 4, 30, 1, 2, 3);
      press(1'b1, 1'b0, 1'b0);
      sel_n(2);
      check("sel_day", 32'(field_sel), 32'd3);
      press(1'b0, 1'b0, 1'b1);
      check("apr30_wrap", 32'(set_day), 32'd1);
      exit_set("ex2", 1'b0, 1'b0);

      // Leap February 2000, then hour/min/sec wraps and field wrap
      set_cur(2000, 2, 28, 23, 59, 59);
      press(1'b1, 1'b0, 1'b0);
      sel_n(2);
      press(1'b0, 1'b0, 1'b1);
      check("feb2000_29", 32'(set_day), 32'd29);
      press(1'b0, 1'b0, 1'b1);
      check("feb2000_wrap", 32'(set_day), 32'd1);
      sel_n(1);
      check("sel_hour", 32'(field_sel), 32'd4);
      press(1'b0, 1'b0, 1'b1);
      check("hour_wrap", 32'(set_hour), 32'd0);
      sel_n(1);
      press(1'b0, 1'b0, 1'b1);
      check("min_wrap", 32'(set_min), 32'd0);
      sel_n(1);
      check("sel_sec", 32'(field_sel), 32'd6);
      press(1'b0, 1'b0, 1'b1);
      check("sec_wrap", 32'(set_sec), 32'd0);
      sel_n(1);
      check("sel_wrap_year", 32'(field_sel), 32'd1);
      exit_set("ex3", 1'b0, 1'b0);

      // Year 9999 wraps to 0; month 12 -> 1 -> 2 clamps day 31 -> 29
      set_cur(9999, 12, 31, 0, 10, 0);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      check("year_wrap", 32'(set_year), 32'd0);
      check("year_wrap_day", 32'(set_day), 32'd31);
      sel_n(1);
      press(1'b0, 1'b0, 1'b1);
      check("month_wrap", 32'(set_month), 32'd1);
      press(1'b0, 1'b0, 1'b1);
      check("feb0_month", 32'(set_month), 32'd2);
      check("feb0_clamp", 32'(set_day), 32'd29);
      exit_set("ex4", 1'b0, 1'b0);

      // Priority: mode+sel+up from S_MIN exits without editing
      set_cur(2024, 5, 15, 8, 10, 20);
      press(1'b1, 1'b0, 1'b0);
      sel_n(4);
      check("sel_min", 32'(field_sel), 32'd5);
      exit_set("prio_all", 1'b1, 1'b1);
      check("prio_all_min", 32'(set_min), 32'd10);

      // Priority: sel+up moves to S_SEC with no increment
      press(1'b1, 1'b0, 1'b0);
      sel_n(4);
      press(1'b0, 1'b1, 1'b1);
      check("prio_su_field", 32'(field_sel), 32'd6);
      check("prio_su_min", 32'(set_min), 32'd10);
      check("prio_su_sec", 32'(set_sec), 32'd20);

      // Reset in S_DAY after an edit
      sel_n(3);
      check("pre_rst_field", 32'(field_sel), 32'd3);
      press(1'b0, 1'b0, 1'b1);
      check("pre_rst_day", 32'(set_day), 32'd16);
      rst = 1'b0;
      #1;
      check("mid_rst_field", 32'(field_sel), 32'd0);
      check("mid_rst_year", 32'(set_year), 32'd2000);
      check("mid_rst_day", 32'(set_day), 32'd1);
      check("mid_rst_blink", 32'(blink), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst_load", 32'(load), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_load", 32'(load), 32'd0);
      clk1sec = 1'b1;
      #1 check("post_rst_tick", 32'(tick_out), 32'd1);
      @(negedge clk);
      clk1sec = 1'b0;
      check("post_rst_load2", 32'(load), 32'd0);
      check("post_rst_field", 32'(field_sel), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
